handshake: RTL and testbench
============================

Name: handshake

Overview:
- Four-phase req/ack receiver that accepts one 8-bit data word per handshake and adds it into a 16-bit running sum.
- Sits at a clock-domain or module boundary where a sender raises req_in with data_in, waits for ack_out, then drops req_in.
- The running total is exposed continuously on sum_out.

Parameters:
- DATA_W, 8, width of data_in.
- SUM_W, 16, width of the accumulator and sum_out. Must be >= DATA_W.
- SYNC_STAGES, 2, number of flops synchronising req_in. Must be >= 1.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rstn  input  1  synchronous, active-high reset (1 = reset). The name is kept for interface compatibility; the polarity is high.
- req_in  input  1  request from the sender; may be asynchronous to clk.
- data_in  input  DATA_W  data word; sender holds it stable from req_in rise until ack_out rise.
- ack_out  output  1  acknowledge to the sender (registered).
- sum_out  output  SUM_W  running sum of accepted words (registered).

Behaviour:
- Reset (rstn=1 at a rising edge):
  - ack_out=0, sum_out=0, FSM=IDLE, all synchroniser flops=0.
  - Reset overrides everything in the same cycle, including a transaction in progress.
- Synchroniser: req_s is req_in delayed through a SYNC_STAGES flop chain. The FSM uses only req_s.
- FSM states are IDLE and ACK.
- IDLE:
  - If req_s=1: sum_out <= sum_out + zero-extended data_in (sampled in this cycle), ack_out <= 1, go to ACK.
  - Otherwise hold all outputs.
- ACK:
  - While req_s=1: ack_out stays 1 and sum_out holds.
  - When req_s=0: ack_out <= 0, go to IDLE.
- Latency:
  - req_in rise to ack_out rise = SYNC_STAGES+1 clocks.
  - req_in fall to ack_out fall = SYNC_STAGES+1 clocks.
- Exactly one accumulation per handshake, however long req_in stays high.
- Width and arithmetic:
  - data_in is zero-extended to SUM_W before the add.
  - The add wraps modulo 2^SUM_W; there is no saturation and no overflow flag.
  - Upper bits driven onto data_in by a wider source are ignored (truncation to DATA_W).
- The next request is not recognised until IDLE has been re-entered, i.e. after ack_out falls. A req_in that rises again while ack_out is still high is taken only once the FSM reaches IDLE.
- After reset is released with req_in already high, IDLE treats it as a new request: one accumulation, then ack.
- req_in pulses shorter than one clock may be missed. The sender must hold req_in until ack_out=1.

Decomposition:
- Package handshake_pkg:
  - state enum {IDLE, ACK}
  - default constants DATA_W=8, SUM_W=16, SYNC_STAGES=2
- Sub-module handshake_sync: parameterised SYNC_STAGES flop chain with synchronous active-high clear.
- The top level holds the FSM and the accumulator.

Test Plan:
- Reset: hold rstn=1 for 10 clocks with req_in=0 -> ack_out=0 and sum_out=0x0000 throughout and after release.
- Single handshake: req_in=1 with data_in=0x41 (driven as 0x4441 from a wider source) -> ack_out rises 3 clocks later, sum_out=0x0041. req_in=0 -> ack_out falls 3 clocks later, sum unchanged.
- Accumulation sequence: handshakes with 0x11, 0x01, 0xFF, 0x1F -> sum_out = 0x0052, 0x0053, 0x0152, 0x0171. Each step changes the sum once, while req_in is held high for 10 clocks.
- Wrap-around: preload the sum to 0xFFF0 via repeated 0xFF handshakes, then send 0x20 -> sum_out wraps to 0x0010 modulo 2^16. No extra ack.
- Protocol: hold req_in high for 50 clocks -> one accumulation only. Toggle data_in while ack_out=1 -> sum_out unaffected.
- Reset mid-transaction: assert rstn=1 while ack_out=1 and req_in=1 -> next edge gives ack_out=0, sum_out=0. Release with req_in still 1 -> exactly one new accumulation of the current data_in (0x01 gives sum_out=0x0001), then ack.

Source files
------------

// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_pkg
//  Description : Shared types and default sizing for the four-phase
//                req/ack accumulating receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package handshake_pkg;

    // Receiver FSM: waiting for a request, or holding the acknowledge.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SUM_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage : handshake_pkg
`default_nettype wire

// File: rtl/handshake_if.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_if
//  Description : Bundle of the req/ack handshake and running-sum signals.
//                The master drives req_in/data_in; the slave answers with
//                ack_out and exposes the accumulated sum_out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface handshake_if
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W
);
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic [SUM_W-1:0]  sum_out;

    modport master (
        output req_in,
        output data_in,
        input  ack_out,
        input  sum_out
    );

    modport slave (
        input  req_in,
        input  data_in,
        output ack_out,
        output sum_out
    );

endinterface : handshake_if
`default_nettype wire

// File: rtl/handshake_sync.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_sync
//  Description : STAGES-deep flop chain bringing a possibly asynchronous
//                single-bit level into the clk domain, with a synchronous
//                active-high clear of every stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    generate
        if (STAGES == 1) begin : g_single
            // Single-stage chain: just capture the input.
            always_ff @(posedge clk) begin
                if (clr_i) chain_q <= 1'b0;
                else       chain_q <= d_i;
            end
        end else begin : g_multi
            // Shift the input through the chain, newest bit in at the bottom.
            always_ff @(posedge clk) begin
                if (clr_i) chain_q <= '0;
                else       chain_q <= {chain_q[STAGES-2:0], d_i};
            end
        end
    endgenerate

    assign q_o = chain_q[STAGES-1];

endmodule : handshake_sync
`default_nettype wire

// File: rtl/handshake.sv
`default_nettype none
// ============================================================================
//  Module      : handshake
//  Description : Four-phase req/ack receiver. Each completed request adds the
//                zero-extended data word into a wrapping running sum, exactly
//                once per handshake regardless of how long req stays high.
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake
    import handshake_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SUM_W       = DEF_SUM_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        rstn,    // active-high despite the name
    handshake_if.slave  bus
);

    logic             req_s;
    state_e           state_q, state_d;
    logic             ack_q,   ack_d;
    logic [SUM_W-1:0] sum_q,   sum_d;

    // req_in may come from another domain; the FSM only ever sees req_s.
    handshake_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .clr_i (rstn),
        .d_i   (bus.req_in),
        .q_o   (req_s)
    );

    // State, acknowledge and accumulator registers; reset wins over all.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            sum_q   <= sum_d;
        end
    end

    // Accumulate on entry to ACK only, so a long-held request adds once;
    // data_in is only sampled in IDLE, so changes during ACK are ignored.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    sum_d   = sum_q + SUM_W'(bus.data_in);
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ack_out = ack_q;
    assign bus.sum_out = sum_q;

endmodule : handshake
`default_nettype wire

// File: tb/tb_handshake.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake
//  Description : Directed self-checking bench for the handshake receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    handshake_if #(.DATA_W(8), .SUM_W(16)) hif ();

    handshake #(
        .DATA_W      (8),
        .SUM_W       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) until ack_out reaches val; sampled on falling edges.
    task automatic wait_ack(input logic val, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (hif.ack_out === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One full four-phase transfer of the low byte of a wider word.
    task automatic do_hs(input logic [15:0] wide, input int hold, output bit ok);
        bit ok_r, ok_f;
        hif.data_in = wide[7:0];
        hif.req_in  = 1'b1;
        wait_ack(1'b1, 20, ok_r);
        repeat (hold) @(negedge clk);
        hif.req_in = 1'b0;
        wait_ack(1'b0, 20, ok_f);
        ok = ok_r && ok_f;
    endtask

    task automatic test_reset();
        rstn        = 1'b1;
        hif.req_in  = 1'b0;
        hif.data_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (hif.ack_out !== 1'b0 || hif.sum_out !== 16'h0000) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: ack=%b sum=%h, want ack=0 sum=0000",
                         i, hif.ack_out, hif.sum_out);
            end
        end
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (hif.ack_out !== 1'b0 || hif.sum_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_release: ack=%b sum=%h, want ack=0 sum=0000",
                     hif.ack_out, hif.sum_out);
        end
    endtask

    task automatic test_single();
        logic [15:0] wide;
        wide        = 16'h4441;
        hif.data_in = wide[7:0];
        hif.req_in  = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (hif.ack_out !== 1'b0) begin
            failures++;
            $display("FAIL single_rise_early: ack=%b want 0", hif.ack_out);
        end
        @(negedge clk);
        checks++;
        if (hif.ack_out !== 1'b1 || hif.sum_out !== 16'h0041) begin
            failures++;
            $display("FAIL single_rise: ack=%b sum=%h, want ack=1 sum=0041",
                     hif.ack_out, hif.sum_out);
        end
        hif.req_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (hif.ack_out !== 1'b1) begin
            failures++;
            $display("FAIL single_fall_early: ack=%b want 1", hif.ack_out);
        end
        @(negedge clk);
        checks++;
        if (hif.ack_out !== 1'b0 || hif.sum_out !== 16'h0041) begin
            failures++;
            $display("FAIL single_fall: ack=%b sum=%h, want ack=0 sum=0041",
                     hif.ack_out, hif.sum_out);
        end
    endtask

    task automatic test_accum();
        logic [7:0]  din [4] = '{8'h11, 8'h01, 8'hFF, 8'h1F};
        logic [15:0] exp [4] = '{16'h0052, 16'h0053, 16'h0152, 16'h0171};
        bit ok;
        for (int k = 0; k < 4; k++) begin
            hif.data_in = din[k];
            hif.req_in  = 1'b1;
            wait_ack(1'b1, 20, ok);
            checks++;
            if (!ok || hif.sum_out !== exp[k]) begin
                failures++;
                $display("FAIL accum_%0d: ok=%b sum=%h, want ack rise sum=%h",
                         k, ok, hif.sum_out, exp[k]);
            end
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                checks++;
                if (hif.sum_out !== exp[k]) begin
                    failures++;
                    $display("FAIL accum_hold_%0d: sum=%h want %h", k, hif.sum_out, exp[k]);
                end
            end
            hif.req_in = 1'b0;
            wait_ack(1'b0, 20, ok);
            checks++;
            if (!ok || hif.sum_out !== exp[k]) begin
                failures++;
                $display("FAIL accum_fall_%0d: ok=%b sum=%h want %h",
                         k, ok, hif.sum_out, exp[k]);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad;
        bad  = 0;
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        // 256 * 0xFF + 0xF0 = 0xFFF0
        for (int k = 0; k < 256; k++) begin
            do_hs(16'h00FF, 0, ok);
            if (!ok) bad++;
        end
        do_hs(16'h00F0, 0, ok);
        if (!ok) bad++;
        checks++;
        if (bad != 0 || hif.sum_out !== 16'hFFF0) begin
            failures++;
            $display("FAIL wrap_preload: timeouts=%0d sum=%h want FFF0", bad, hif.sum_out);
        end
        do_hs(16'h0020, 0, ok);
        checks++;
        if (!ok || hif.sum_out !== 16'h0010) begin
            failures++;
            $display("FAIL wrap: ok=%b sum=%h want 0010", ok, hif.sum_out);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (hif.ack_out !== 1'b0 || hif.sum_out !== 16'h0010) begin
                failures++;
                $display("FAIL wrap_idle: ack=%b sum=%h want ack=0 sum=0010",
                         hif.ack_out, hif.sum_out);
            end
        end
    endtask

    task automatic test_protocol();
        bit ok;
        hif.data_in = 8'h05;
        hif.req_in  = 1'b1;
        wait_ack(1'b1, 20, ok);
        checks++;
        if (!ok || hif.sum_out !== 16'h0015) begin
            failures++;
            $display("FAIL proto_accept: ok=%b sum=%h want 0015", ok, hif.sum_out);
        end
        for (int c = 0; c < 50; c++) begin
            hif.data_in = 8'(c * 37 + 3);
            @(negedge clk);
            checks++;
            if (hif.ack_out !== 1'b1 || hif.sum_out !== 16'h0015) begin
                failures++;
                $display("FAIL proto_hold cyc%0d: ack=%b sum=%h want ack=1 sum=0015",
                         c, hif.ack_out, hif.sum_out);
            end
        end
        hif.req_in = 1'b0;
        wait_ack(1'b0, 20, ok);
        checks++;
        if (!ok || hif.sum_out !== 16'h0015) begin
            failures++;
            $display("FAIL proto_release: ok=%b sum=%h want 0015", ok, hif.sum_out);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        hif.data_in = 8'h01;
        hif.req_in  = 1'b1;
        wait_ack(1'b1, 20, ok);
        checks++;
        if (!ok || hif.sum_out !== 16'h0016) begin
            failures++;
            $display("FAIL rmid_pre: ok=%b sum=%h want 0016", ok, hif.sum_out);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (hif.ack_out !== 1'b0 || hif.sum_out !== 16'h0000) begin
            failures++;
            $display("FAIL rmid_reset: ack=%b sum=%h want ack=0 sum=0000",
                     hif.ack_out, hif.sum_out);
        end
        rstn = 1'b0;
        wait_ack(1'b1, 20, ok);
        checks++;
        if (!ok || hif.sum_out !== 16'h0001) begin
            failures++;
            $display("FAIL rmid_reaccept: ok=%b sum=%h want 0001", ok, hif.sum_out);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (hif.ack_out !== 1'b1 || hif.sum_out !== 16'h0001) begin
            failures++;
            $display("FAIL rmid_hold: ack=%b sum=%h want ack=1 sum=0001",
                     hif.ack_out, hif.sum_out);
        end
        hif.req_in = 1'b0;
        wait_ack(1'b0, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rmid_fall: ack=%b want 0 (timeout)", hif.ack_out);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        hif.data_in = 8'h03;
        hif.req_in  = 1'b1;
        wait_ack(1'b1, 20, ok);
        // Drop req for a single clock, then re-raise with new data while ack is high.
        hif.req_in = 1'b0;
        @(negedge clk);
        hif.data_in = 8'h04;
        hif.req_in  = 1'b1;
        checks++;
        if (!ok || hif.ack_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: ok=%b ack=%b want ack=1", ok, hif.ack_out);
        end
        wait_ack(1'b0, 20, ok);
        checks++;
        if (!ok || hif.sum_out !== 16'h0004) begin
            failures++;
            $display("FAIL b2b_gap: ok=%b sum=%h want 0004", ok, hif.sum_out);
        end
        wait_ack(1'b1, 20, ok);
        checks++;
        if (!ok || hif.sum_out !== 16'h0008) begin
            failures++;
            $display("FAIL b2b_second: ok=%b sum=%h want 0008", ok, hif.sum_out);
        end
        hif.req_in = 1'b0;
        wait_ack(1'b0, 20, ok);
        checks++;
        if (!ok || hif.sum_out !== 16'h0008) begin
            failures++;
            $display("FAIL b2b_end: ok=%b sum=%h want 0008", ok, hif.sum_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_accum();
        test_wrap();
        test_protocol();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_handshake
`default_nettype wire
